// File: rtl/hamming74_encoder_if.sv
// FIFO-side signals of the Hamming(7,4) encoder.
// master: encoder side (drives read/write strobes and output data).
// slave : FIFO side (drives input data and the empty/full flags).
interface hamming74_encoder_if;
  logic FIFO_IN_DATA;
  logic FIFO_IN_RE;
  logic FIFO_IN_EMPTY;
  logic FIFO_OUT_DATA;
  logic FIFO_OUT_WE;
  logic FIFO_OUT_FULL;

  modport master (
    input  FIFO_IN_DATA,
    input  FIFO_IN_EMPTY,
    input  FIFO_OUT_FULL,
    output FIFO_IN_RE,
    output FIFO_OUT_DATA,
    output FIFO_OUT_WE
  );

  modport slave (
    output FIFO_IN_DATA,
    output FIFO_IN_EMPTY,
    output FIFO_OUT_FULL,
    input  FIFO_IN_RE,
    input  FIFO_OUT_DATA,
    input  FIFO_OUT_WE
  );
endinterface

// File: rtl/hamming74_encoder.sv
// Hamming(7,4) channel encoder.
// Reads 4 information bits from the input FIFO (one-cycle read latency),
// then writes the 7-bit codeword p1,p2,d1,p3,d2,d3,d4 bit-serially to the
// output FIFO, stalling on EMPTY while collecting and on FULL while emitting.
module hamming74_encoder #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  hamming74_encoder_if.master  fifo,
  output logic [CNT_WIDTH-1:0] CODEWORD_CNT
);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_EMIT    = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [2:0]           r_reads_issued;  // reads issued for the current word, 0..4
  logic                 r_pending;       // a read was issued last cycle
  logic [1:0]           r_captured;      // data slot the next returned bit lands in
  logic [2:0]           r_data;          // d1..d3; d4 goes straight into the codeword
  logic [6:0]           r_codeword;      // bit 0 is transmitted first
  logic [2:0]           r_index;         // next codeword bit to write
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_re;
  logic                 w_we;
  logic                 w_capture;
  logic                 w_last_capture;
  logic                 w_last_write;
  logic [3:0]           w_word;
  logic [6:0]           w_codeword;

  // Word being completed this cycle: held slots plus the bit arriving now.
  assign w_word = {fifo.FIFO_IN_DATA, r_data};

  // Parity and transmit ordering of the codeword.
  always_comb begin
    w_codeword    = '0;
    w_codeword[0] = w_word[0] ^ w_word[1] ^ w_word[3];  // p1
    w_codeword[1] = w_word[0] ^ w_word[2] ^ w_word[3];  // p2
    w_codeword[2] = w_word[0];                           // d1
    w_codeword[3] = w_word[1] ^ w_word[2] ^ w_word[3];  // p3
    w_codeword[4] = w_word[1];                           // d2
    w_codeword[5] = w_word[2];                           // d3
    w_codeword[6] = w_word[3];                           // d4
  end

  // Next-state and strobe decode; RESET gates RE so outputs are quiet while held in reset.
  always_comb begin
    w_state_next   = r_state;
    w_re           = 1'b0;
    w_we           = 1'b0;
    w_capture      = 1'b0;
    w_last_capture = 1'b0;
    w_last_write   = 1'b0;
    case (r_state)
      S_COLLECT: begin
        w_re           = !RESET && !fifo.FIFO_IN_EMPTY && (r_reads_issued < 3'd4);
        w_capture      = r_pending;
        w_last_capture = r_pending && (r_captured == 2'd3);
        if (w_last_capture) begin
          w_state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        w_we         = !fifo.FIFO_OUT_FULL;
        w_last_write = w_we && (r_index == 3'd6);
        if (w_last_write) begin
          w_state_next = S_COLLECT;
        end
      end
      default: begin
        w_state_next = S_COLLECT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Read side: issue counting, one-cycle-late capture into the data slots.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_reads_issued <= '0;
      r_pending      <= 1'b0;
      r_captured     <= '0;
      r_data         <= '0;
    end else begin
      r_pending <= w_re;
      if (w_last_write) begin
        r_reads_issued <= '0;
      end else if (w_re) begin
        r_reads_issued <= r_reads_issued + 3'd1;
      end
      if (w_capture) begin
        if (w_last_capture) begin
          r_captured <= '0;
        end else begin
          r_data[r_captured] <= fifo.FIFO_IN_DATA;
          r_captured         <= r_captured + 2'd1;
        end
      end
    end
  end

  // Emit side: load the codeword on the 4th capture, advance only on accepted writes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_codeword <= '0;
      r_index    <= '0;
    end else if (w_last_capture) begin
      r_codeword <= w_codeword;
      r_index    <= '0;
    end else if (w_we) begin
      r_index <= w_last_write ? 3'd0 : (r_index + 3'd1);
    end
  end

  // Completed-codeword counter, wraps naturally.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (w_last_write) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign fifo.FIFO_IN_RE   = w_re;
  assign fifo.FIFO_OUT_WE  = w_we;
  assign fifo.FIFO_OUT_DATA = (r_state == S_EMIT) ? r_codeword[r_index] : r_codeword[0];
  assign CODEWORD_CNT      = r_cnt;

endmodule

// File: tb/tb_hamming74_encoder.sv
// Bench for hamming74_encoder: behavioural FIFOs on both sides, a
// position-based Hamming(7,4) reference model, and one task per scenario.
module tb_hamming74_encoder;
  localparam int CW = 3;  // narrow counter so wrap-around is reached

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [CW-1:0] cnt;

  hamming74_encoder_if bus ();

  hamming74_encoder #(.CNT_WIDTH(CW)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .fifo         (bus),
    .CODEWORD_CNT (cnt)
  );

  always #5 CLK = ~CLK;

  bit in_q[$];     // contents of the input FIFO
  bit exp_q[$];    // expected output bits for the current scenario
  bit out_log[$];  // bits actually written
  int we_log[$];   // cycle numbers of writes
  int re_log[$];   // cycle numbers of reads
  int cyc = 0;
  bit pend_valid = 1'b0;
  bit pend_bit = 1'b0;
  bit force_empty = 1'b0;
  bit force_full = 1'b0;
  int exp_cnt = 0;
  int n_vec = 0;
  int n_err = 0;

  // Reference: place data at positions 3,5,6,7; parity at position 2^k covers
  // every position whose index has bit k set. Returned bit j-1 = position j.
  function automatic logic [6:0] ref_encode(input logic [3:0] d);
    logic [7:1] pos;
    int p;
    bit acc;
    pos = '0;
    pos[3] = d[0];
    pos[5] = d[1];
    pos[6] = d[2];
    pos[7] = d[3];
    for (int k = 0; k < 3; k++) begin
      p = 1 << k;
      acc = 1'b0;
      for (int j = 1; j <= 7; j++) begin
        if (((j & p) != 0) && (j != p)) acc ^= pos[j];
      end
      pos[p] = acc;
    end
    return pos[7:1];
  endfunction

  function automatic int syndrome(input logic [6:0] cwd);
    int s;
    s = 0;
    for (int j = 1; j <= 7; j++) if (cwd[j-1]) s ^= j;
    return s;
  endfunction

  // FIFO models: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
  initial begin
    bus.FIFO_IN_DATA  = 1'b0;
    bus.FIFO_IN_EMPTY = 1'b1;
    bus.FIFO_OUT_FULL = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (pend_valid) bus.FIFO_IN_DATA = pend_bit;
      pend_valid = 1'b0;
      bus.FIFO_IN_EMPTY = force_empty || (in_q.size() == 0);
      bus.FIFO_OUT_FULL = force_full;
      @(negedge CLK);
      if (bus.FIFO_IN_RE === 1'b1 && in_q.size() > 0) begin
        pend_bit = in_q.pop_front();
        pend_valid = 1'b1;
        re_log.push_back(cyc);
      end
      if (bus.FIFO_OUT_WE === 1'b1) begin
        out_log.push_back(bus.FIFO_OUT_DATA);
        we_log.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    out_log.delete();
    we_log.delete();
    re_log.delete();
    exp_q.delete();
  endtask

  task automatic push_word(input logic [3:0] d);
    logic [6:0] cwd;
    cwd = ref_encode(d);
    for (int i = 0; i < 4; i++) in_q.push_back(d[i]);
    for (int i = 0; i < 7; i++) exp_q.push_back(cwd[i]);
    exp_cnt++;
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    int b;
    b = 0;
    while (we_log.size() < n && b < budget) begin
      tick();
      b++;
    end
    ok = (we_log.size() >= n);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    clear_logs();
    push_word(4'b1101);  // d1..d4 = 1,0,1,1
    tick();
    tick();
    n_vec++;
    if (bus.FIFO_IN_RE !== 1'b0) begin
      n_err++;
      $display("FAIL reset_re: got %b want 0", bus.FIFO_IN_RE);
    end
    n_vec++;
    if (bus.FIFO_OUT_WE !== 1'b0) begin
      n_err++;
      $display("FAIL reset_we: got %b want 0", bus.FIFO_OUT_WE);
    end
    n_vec++;
    if (bus.FIFO_OUT_DATA !== 1'b0) begin
      n_err++;
      $display("FAIL reset_data: got %b want 0", bus.FIFO_OUT_DATA);
    end
    n_vec++;
    if (cnt !== '0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d want 0", cnt);
    end
    $display("reset: outputs checked with input FIFO non-empty");
    @(posedge CLK);
    #2;
    exp_cnt = 1;
    RESET = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    logic [6:0] spec_cw;
    spec_cw = 7'b1100110;  // written order 0,1,1,0,0,1,1
    wait_writes(7, 40, ok);
    tick();
    n_vec++;
    if (!ok || re_log.size() != 4) begin
      n_err++;
      $display("FAIL basic_counts: got %0d reads %0d writes want 4 and 7", re_log.size(), we_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (re_log[i] - re_log[0] != i) begin
          n_err++;
          $display("FAIL basic_re_cycle[%0d]: got %0d want %0d", i, re_log[i] - re_log[0], i);
        end
      end
      for (int i = 0; i < 7; i++) begin
        n_vec++;
        if (we_log[i] - re_log[0] != 5 + i || out_log[i] !== spec_cw[i]) begin
          n_err++;
          $display("FAIL basic_bit[%0d]: got cycle %0d bit %b want cycle %0d bit %b",
                   i, we_log[i] - re_log[0], out_log[i], 5 + i, spec_cw[i]);
        end
      end
    end
    n_vec++;
    if (cnt !== 3'(exp_cnt)) begin
      n_err++;
      $display("FAIL basic_cnt: got %0d want %0d", cnt, exp_cnt);
    end
    $display("basic: word 1011 -> %0d bits written, cnt %0d", out_log.size(), cnt);
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    push_word(4'b0000);
    push_word(4'b1111);
    wait_writes(14, 80, ok);
    repeat (4) tick();
    n_vec++;
    if (we_log.size() != 14 || re_log.size() != 8) begin
      n_err++;
      $display("FAIL b2b_counts: got %0d writes %0d reads want 14 and 8", we_log.size(), re_log.size());
    end else begin
      n_vec++;
      if (re_log[4] - re_log[0] != 12) begin
        n_err++;
        $display("FAIL b2b_second_re: got cycle %0d want 12", re_log[4] - re_log[0]);
      end
      for (int i = 0; i < 14; i++) begin
        n_vec++;
        if (out_log[i] !== exp_q[i] || out_log[i] !== (i >= 7)) begin
          n_err++;
          $display("FAIL b2b_bit[%0d]: got %b want %b", i, out_log[i], exp_q[i]);
        end
      end
    end
    n_vec++;
    if (cnt !== 3'(exp_cnt)) begin
      n_err++;
      $display("FAIL b2b_cnt: got %0d want %0d", cnt, exp_cnt);
    end
    $display("back_to_back: 0000,1111 -> %0d writes, cnt %0d", we_log.size(), cnt);
  endtask

  task automatic test_exhaustive();
    logic [3:0] words[22];
    logic [3:0] t;
    logic [6:0] got;
    int idx;
    int b;
    clear_logs();
    for (int i = 0; i < 16; i++) words[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      idx = $urandom_range(0, i);
      t = words[i];
      words[i] = words[idx];
      words[idx] = t;
    end
    for (int i = 16; i < 22; i++) words[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 22; i++) push_word(words[i]);
    b = 0;
    while (we_log.size() < 154 && b < 3000) begin
      force_empty = ($urandom_range(0, 3) == 0);
      force_full = ($urandom_range(0, 4) == 0);
      tick();
      b++;
    end
    force_empty = 1'b0;
    force_full = 1'b0;
    repeat (4) tick();
    n_vec++;
    if (we_log.size() != 154) begin
      n_err++;
      $display("FAIL exh_count: got %0d writes want 154", we_log.size());
    end else begin
      for (int w = 0; w < 22; w++) begin
        for (int i = 0; i < 7; i++) begin
          got[i] = out_log[w*7 + i];
          n_vec++;
          if (out_log[w*7 + i] !== exp_q[w*7 + i]) begin
            n_err++;
            $display("FAIL exh_bit[w%0d b%0d]: got %b want %b (word %b)",
                     w, i, out_log[w*7 + i], exp_q[w*7 + i], words[w]);
          end
        end
        n_vec++;
        if (syndrome(got) != 0) begin
          n_err++;
          $display("FAIL exh_syndrome[w%0d]: got %0d want 0", w, syndrome(got));
        end
      end
    end
    n_vec++;
    if (cnt !== 3'(exp_cnt)) begin
      n_err++;
      $display("FAIL exh_cnt: got %0d want %0d", cnt, exp_cnt[CW-1:0]);
    end
    $display("exhaustive: 22 words with random gaps, %0d bits written, cnt %0d", we_log.size(), cnt);
  endtask

  task automatic test_full_stall();
    bit ok;
    logic [3:0] d;
    clear_logs();
    d = 4'($urandom_range(0, 15));
    push_word(d);
    wait_writes(3, 40, ok);
    force_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (bus.FIFO_OUT_WE !== 1'b0 || bus.FIFO_OUT_DATA !== exp_q[3]) begin
        n_err++;
        $display("FAIL full_stall[%0d]: got we %b data %b want we 0 data %b",
                 i, bus.FIFO_OUT_WE, bus.FIFO_OUT_DATA, exp_q[3]);
      end
    end
    n_vec++;
    if (we_log.size() != 3) begin
      n_err++;
      $display("FAIL full_writes_during_stall: got %0d want 3", we_log.size());
    end
    force_full = 1'b0;
    wait_writes(7, 20, ok);
    repeat (3) tick();
    n_vec++;
    if (we_log.size() != 7) begin
      n_err++;
      $display("FAIL full_count: got %0d writes want 7", we_log.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_vec++;
        if (out_log[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL full_bit[%0d]: got %b want %b", i, out_log[i], exp_q[i]);
        end
      end
    end
    n_vec++;
    if (cnt !== 3'(exp_cnt)) begin
      n_err++;
      $display("FAIL full_cnt: got %0d want %0d", cnt, exp_cnt[CW-1:0]);
    end
    $display("full_stall: word %b, 10-cycle stall after 3 bits, %0d bits written", d, we_log.size());
  endtask

  task automatic test_empty_stall();
    bit ok;
    int b;
    logic [3:0] d;
    logic [6:0] cwd;
    clear_logs();
    d = 4'($urandom_range(0, 15));
    cwd = ref_encode(d);
    for (int i = 0; i < 7; i++) exp_q.push_back(cwd[i]);
    exp_cnt++;
    in_q.push_back(d[0]);
    in_q.push_back(d[1]);
    b = 0;
    while (re_log.size() < 2 && b < 20) begin
      tick();
      b++;
    end
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (bus.FIFO_IN_RE !== 1'b0 || bus.FIFO_OUT_WE !== 1'b0) begin
        n_err++;
        $display("FAIL empty_stall[%0d]: got re %b we %b want 0 0", i, bus.FIFO_IN_RE, bus.FIFO_OUT_WE);
      end
    end
    in_q.push_back(d[2]);
    in_q.push_back(d[3]);
    wait_writes(7, 40, ok);
    repeat (3) tick();
    n_vec++;
    if (we_log.size() != 7 || re_log.size() != 4) begin
      n_err++;
      $display("FAIL empty_counts: got %0d writes %0d reads want 7 and 4", we_log.size(), re_log.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_vec++;
        if (out_log[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL empty_bit[%0d]: got %b want %b", i, out_log[i], exp_q[i]);
        end
      end
    end
    $display("empty_stall: word %b split 2+2 around a 20-cycle gap, %0d bits written", d, we_log.size());
  endtask

  task automatic test_reset_emit();
    bit ok;
    logic [3:0] d_old;
    logic [3:0] d_new;
    logic [6:0] cwd;
    clear_logs();
    d_old = 4'($urandom_range(0, 15));
    d_new = d_old ^ 4'($urandom_range(1, 15));
    push_word(d_old);
    wait_writes(4, 40, ok);
    for (int i = 0; i < 4; i++) in_q.push_back(d_new[i]);
    RESET = 1'b1;
    #1;
    n_vec++;
    if (bus.FIFO_IN_RE !== 1'b0 || bus.FIFO_OUT_WE !== 1'b0 || cnt !== '0) begin
      n_err++;
      $display("FAIL reset_emit_async: got re %b we %b cnt %0d want 0 0 0",
               bus.FIFO_IN_RE, bus.FIFO_OUT_WE, cnt);
    end
    tick();
    tick();
    n_vec++;
    if (bus.FIFO_IN_RE !== 1'b0 || bus.FIFO_OUT_WE !== 1'b0) begin
      n_err++;
      $display("FAIL reset_emit_held: got re %b we %b want 0 0", bus.FIFO_IN_RE, bus.FIFO_OUT_WE);
    end
    @(posedge CLK);
    #2;
    clear_logs();
    cwd = ref_encode(d_new);
    for (int i = 0; i < 7; i++) exp_q.push_back(cwd[i]);
    exp_cnt = 1;
    RESET = 1'b0;
    wait_writes(7, 40, ok);
    repeat (6) tick();
    n_vec++;
    if (we_log.size() != 7) begin
      n_err++;
      $display("FAIL reset_emit_count: got %0d writes want 7", we_log.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_vec++;
        if (out_log[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL reset_emit_bit[%0d]: got %b want %b", i, out_log[i], exp_q[i]);
        end
      end
    end
    n_vec++;
    if (cnt !== 3'(exp_cnt)) begin
      n_err++;
      $display("FAIL reset_emit_cnt: got %0d want %0d", cnt, exp_cnt);
    end
    $display("reset_emit: old %b dropped after 4 bits, new %b -> %0d bits, cnt %0d",
             d_old, d_new, we_log.size(), cnt);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_exhaustive();
    test_full_stall();
    test_empty_stall();
    test_reset_emit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
